alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 47 ++++
 rtl/alu_pipe_mul.sv | 53 +++++
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Opcode map, FSM states and op-class decode for the pipelined ALU.
// Latency: n/a (package). Backpressure: n/a.
package alu_pipe_pkg;

    localparam logic [4:0] OP_ADD      = 5'b11111;
    localparam logic [4:0] OP_ADD_ALT  = 5'b00001;
    localparam logic [4:0] OP_COMP     = 5'b10000;
    localparam logic [4:0] OP_COMP_ALT = 5'b00010;
    localparam logic [4:0] OP_AND      = 5'b00011;
    localparam logic [4:0] OP_XOR      = 5'b00100;
    localparam logic [4:0] OP_DIFF     = 5'b01111;
    localparam logic [4:0] OP_MUL      = 5'b11000;
    localparam logic [4:0] OP_SLL      = 5'b10001;
    localparam logic [4:0] OP_SRL      = 5'b10010;
    localparam logic [4:0] OP_SRA      = 5'b10101;
    localparam logic [4:0] OP_SLLV     = 5'b10011;
    localparam logic [4:0] OP_SRLV     = 5'b10100;
    localparam logic [4:0] OP_SRAV     = 5'b10110;

    typedef enum logic {IDLE, MUL} state_t;

    typedef enum logic [3:0] {
        CLS_PASS, CLS_ADD, CLS_COMP, CLS_AND, CLS_XOR, CLS_DIFF, CLS_MUL,
        CLS_SLL, CLS_SRL, CLS_SRA, CLS_SLLV, CLS_SRLV, CLS_SRAV
    } op_cls_t;

    function automatic op_cls_t op_class(input logic [4:0] op);
        op_cls_t cls;
        case (op)
            OP_ADD, OP_ADD_ALT:   cls = CLS_ADD;
            OP_COMP, OP_COMP_ALT: cls = CLS_COMP;
            OP_AND:               cls = CLS_AND;
            OP_XOR:               cls = CLS_XOR;
            OP_DIFF:              cls = CLS_DIFF;
            OP_MUL:               cls = CLS_MUL;
            OP_SLL:               cls = CLS_SLL;
            OP_SRL:               cls = CLS_SRL;
            OP_SRA:               cls = CLS_SRA;
            OP_SLLV:              cls = CLS_SLLV;
            OP_SRLV:              cls = CLS_SRLV;
            OP_SRAV:              cls = CLS_SRAV;
            default:              cls = CLS_PASS;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per enabled cycle.
// Latency: start edge plus WIDTH enabled steps; done/product are valid during the final step.
// Backpressure: en low freezes the step sequence, so a finished product waits for its consumer.
module alu_pipe_mul #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    import alu_pipe_pkg::*;

    logic                 busy;
    logic [SHW-1:0]       cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       sum;

    // Multiplier lives in the low half of acc and is consumed LSB-first as the
    // accumulated partial product shifts right into its place.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign done     = busy && en && (cnt == SHW'(WIDTH - 1));
    assign product  = acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
        end else if (busy && en) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with one output register stage and an iterative multiply path.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul (accept to out_valid).
// Backpressure: in_ready drops while a result is held or a mul is in flight; held outputs stay stable.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       control_ALUop,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             sign_bit,
    output logic             zero_flag
);
    import alu_pipe_pkg::*;

    state_t             state;
    op_cls_t            cls;
    logic               accept;
    logic               is_mul;
    logic               stall;
    logic               load;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     add_sum;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic [WIDTH-1:0]   ld_res;
    logic               ld_carry;

    assign cls      = op_class(control_ALUop);
    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (cls == CLS_MUL);
    assign stall    = out_valid && !out_ready;
    assign add_sum  = {1'b0, input1} + {1'b0, input2};

    // Immediate shifts take their amount from the shamt field starting at bit 6.
    always_comb begin
        shamt = input2[SHW-1:0];
        if (cls == CLS_SLL || cls == CLS_SRL || cls == CLS_SRA) begin
            shamt = SHW'(input2 >> 6);
        end
    end

    always_comb begin
        alu_res   = input1;
        alu_carry = 1'b0;
        case (cls)
            CLS_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
            end
            CLS_COMP:             alu_res = '0 - input2;
            CLS_AND:              alu_res = input1 & input2;
            CLS_XOR:              alu_res = input1 ^ input2;
            CLS_SLL, CLS_SLLV:    alu_res = input1 << shamt;
            CLS_SRL, CLS_SRLV:    alu_res = input1 >> shamt;
            CLS_SRA, CLS_SRAV:    alu_res = $unsigned($signed(input1) >>> shamt);
            CLS_DIFF: begin
                alu_res = WIDTH'(WIDTH);
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (input1[i] != input2[i]) begin
                        alu_res = WIDTH'(i);
                    end
                end
            end
            default: alu_res = input1;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        ld_res   = alu_res;
        ld_carry = alu_carry;
        if (state == MUL) begin
            load     = mul_done;
            ld_res   = mul_prod[WIDTH-1:0];
            ld_carry = |mul_prod[2*WIDTH-1:WIDTH];
        end else begin
            load = accept && !is_mul;
        end
    end

    alu_pipe_mul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .en      (!stall),
        .a       (input1),
        .b       (input2),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            sign_bit  <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            if (load) begin
                result    <= ld_res;
                carry     <= ld_carry;
                sign_bit  <= ld_res[WIDTH-1];
                zero_flag <= (ld_res == '0);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: if (accept && is_mul) state <= MUL;
                MUL:  if (mul_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against an in-bench reference model.
module tb_alu_pipe;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready, out_valid, carry, sign_bit, zero_flag;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        c;
    } exp_t;
    exp_t q[$];
    exp_t e_pop;

    bit          hold = 1'b0;
    logic [31:0] h_res;
    logic [2:0]  h_fl;

    alu_pipe #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .control_ALUop (op),
        .input1        (a),
        .input2        (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry         (carry),
        .sign_bit      (sign_bit),
        .zero_flag     (zero_flag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        logic [32:0] s;
        logic [31:0] d;
        int          si;
        int          sv;
        si = int'(y[10:6]);
        sv = int'(y[4:0]);
        e.c = 1'b0;
        e.res = x;
        case (o)
            5'b11111, 5'b00001: begin
                s = {1'b0, x} + {1'b0, y};
                e.res = s[31:0];
                e.c = s[32];
            end
            5'b10000, 5'b00010: e.res = 32'd0 - y;
            5'b00011: e.res = x & y;
            5'b00100: e.res = x ^ y;
            5'b01111: begin
                d = x ^ y;
                e.res = 32;
                for (int i = 0; i < 32; i++) begin
                    if (d[i]) begin
                        e.res = i;
                        break;
                    end
                end
            end
            5'b11000: begin
                p = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
                e.c = (p[63:32] != 0);
            end
            5'b10001: e.res = x << si;
            5'b10010: e.res = x >> si;
            5'b10101: e.res = $signed(x) >>> si;
            5'b10011: e.res = x << sv;
            5'b10100: e.res = x >> sv;
            5'b10110: e.res = $signed(x) >>> sv;
            default:  e.res = x;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: pops one model entry per output transfer, records accepts, checks held outputs.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", result, h_res);
                chk("hold_flags", {carry, sign_bit, zero_flag}, h_fl);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e_pop = q.pop_front();
                    chk("sb_result", result, e_pop.res);
                    chk("sb_carry", carry, e_pop.c);
                    chk("sb_sign", sign_bit, e_pop.res[31]);
                    chk("sb_zero", zero_flag, e_pop.res == 0);
                end
            end
            if (in_valid && in_ready) q.push_back(model(op, a, b));
            hold = out_valid && !out_ready;
            h_res = result;
            h_fl = {carry, sign_bit, zero_flag};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        bit fin;
        n = 0;
        fin = 1'b0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!fin) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                fin = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    chk("accept_timeout", in_ready, 1);
                    fin = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_dir(input string nm, input logic [4:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] er, input logic ec,
                           input logic es, input logic ez, input int elat, input int elo);
        int lat;
        int lo;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        send(o, x, y);
        lat = 1;
        lo = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 100) break;
            if (!in_ready) lo++;
            lat++;
            tick();
        end
        chk({nm, "_result"}, result, er);
        chk({nm, "_carry"}, carry, ec);
        chk({nm, "_sign"}, sign_bit, es);
        chk({nm, "_zero"}, zero_flag, ez);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_ready_low"}, lo, elo);
        tick();
    endtask

    initial begin
        logic [4:0] ops [16] = '{5'b11111, 5'b00001, 5'b10000, 5'b00010, 5'b00011, 5'b00100,
                                 5'b01111, 5'b11000, 5'b10001, 5'b10010, 5'b10101, 5'b10011,
                                 5'b10100, 5'b10110, 5'b00000, 5'b01010};
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, sign_bit, zero_flag}, 0);
        chk("rst_in_ready_high", in_ready, 1);
        tick();

        run_dir("add_small", 5'b11111, 32'd30037, 32'd30049, 32'd60086, 0, 0, 0, 1, 0);
        run_dir("add_carry", 5'b00001, 32'hF03FF0FB, 32'hAFC00F05, 32'hA0000000, 1, 1, 0, 1, 0);
        run_dir("sra_imm", 5'b10101, 32'hF3F00FCF, 32'h00000240, 32'hFFF9F807, 0, 1, 0, 1, 0);
        run_dir("diff_bit8", 5'b01111, 32'h3AA04244, 32'h3AA04344, 32'd8, 0, 0, 0, 1, 0);
        run_dir("diff_equal", 5'b01111, 32'h12345678, 32'h12345678, 32'd32, 0, 0, 0, 1, 0);
        run_dir("comp_one", 5'b10000, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 1, 0, 1, 0);
        run_dir("mul_small", 5'b11000, 32'd1234, 32'd5678, 32'h006AE9BC, 0, 0, 0, 33, 32);
        run_dir("mul_ovf", 5'b11000, 32'h10000, 32'h10000, 32'd0, 1, 0, 1, 33, 32);

        // Backpressure: one result held while the next op waits.
        out_ready = 1'b0;
        send(5'b11111, 32'd5, 32'd7);
        op = 5'b00100;
        a = 32'hF0;
        b = 32'h0F;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        send(5'b00100, 32'hF0, 32'h0F);
        send(5'b00011, 32'hFF00FF00, 32'h0FF00FF0);
        send(5'b10010, 32'h80000000, 32'h000007C0);
        repeat (3) tick();

        // Reset during the tenth cycle of a multiply.
        send(5'b11000, 32'd3, 32'd5);
        repeat (9) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {carry, sign_bit, zero_flag}, 0);
        chk("midrst_in_ready", in_ready, 1);
        tick();
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        chk("midrst_no_ghost", seen, 0);

        rand_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) tick();
            send(ops[$urandom_range(0, 15)], ra, rb);
        end

        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) tick();
        repeat (2) tick();
        chk("drain_empty", q.size(), 0);
        chk("drain_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
